// File: rtl/mm_timer_slave.sv
// Memory-mapped down-counting timer: CTRL/LOAD/COUNT/STATUS at word offsets 0..3.
// Optional prescaler in CTRL[8 +: PRESC_WIDTH] when TIMER_PRESCALER_EN is defined.
module mm_timer_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [31:0]           address,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  o_expired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, nxt;

  logic [1:0]            off;
  logic                  wr_ctrl;
  logic                  wr_load;
  logic                  wr_stat;
  logic                  auto_rel;
  logic [DATA_WIDTH-1:0] load;
  logic [DATA_WIDTH-1:0] count;
  logic                  expired;
  logic                  presc_hit;
  logic                  tick;
  logic                  expire;
  logic                  reload;
  logic                  unused_addr;

  assign off         = address[3:2];
  assign unused_addr = ^{address[31:4], address[1:0]};
  assign wr_ctrl     = we && (off == 2'd0);
  assign wr_load     = we && (off == 2'd1);
  assign wr_stat     = we && (off == 2'd3);

`ifdef TIMER_PRESCALER_EN
  logic [PRESC_WIDTH-1:0] presc;
  logic [PRESC_WIDTH-1:0] pcnt;

  assign presc_hit = (pcnt >= presc);

  // prescaler restarts on a reload write and stays at 0 outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (state != RUN || wr_load || presc_hit) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (wr_ctrl) begin
      presc <= wd[8 +: PRESC_WIDTH];
    end
  end
`else
  assign presc_hit = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (wr_ctrl && wd[0]) nxt = RUN;
      end
      RUN: begin
        if (wr_ctrl && !wd[0]) nxt = IDLE;
        else if (expire && !reload) nxt = DONE;
      end
      DONE: begin
        if (wr_ctrl) nxt = wd[0] ? RUN : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // a LOAD write or a disabling CTRL write pre-empts the tick on that edge
  always_comb begin
    tick   = 1'b0;
    expire = 1'b0;
    reload = 1'b0;
    if (state == RUN && !wr_load &&
        !(wr_ctrl && !wd[0]) && presc_hit) begin
      tick = 1'b1;
      if (count == '0) begin
        expire = 1'b1;
        reload = auto_rel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_rel <= 1'b0;
    end else if (wr_ctrl) begin
      auto_rel <= wd[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load  <= '0;
      count <= '0;
    end else if (wr_load) begin
      load  <= wd;
      count <= wd;
    end else if (tick) begin
      if (count != '0) count <= count - 1'b1;
      else if (reload) count <= load;
    end
  end

  // a new expiry beats a same-edge W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expired <= 1'b0;
    end else if (expire) begin
      expired <= 1'b1;
    end else if (wr_stat && wd[0]) begin
      expired <= 1'b0;
    end
  end

  always_comb begin
    rd = '0;
    unique case (off)
      2'd0: begin
        rd[0] = (state == RUN);
        rd[1] = auto_rel;
`ifdef TIMER_PRESCALER_EN
        rd[8 +: PRESC_WIDTH] = presc;
`endif
      end
      2'd1: rd = load;
      2'd2: rd = count;
      2'd3: rd[0] = expired;
      default: rd = '0;
    endcase
  end

  assign o_expired = expired;

endmodule

// File: tb/tb_mm_timer_slave.sv
// Scoreboard bench for mm_timer_slave: expectations queued, then
// drained against rd / o_expired between clock edges.
module tb_mm_timer_slave;

  localparam int CTRL  = 0;
  localparam int LOAD  = 1;
  localparam int COUNT = 2;
  localparam int STAT  = 3;
  localparam int EXPO  = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] wd;
  logic [31:0] address;
  logic        we;
  logic [31:0] rd;
  logic        o_expired;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;

  mm_timer_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wd        (wd),
    .address   (address),
    .we        (we),
    .rd        (rd),
    .o_expired (o_expired)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push(input int sel,
                      input logic [31:0] v,
                      input string tag);
    exp_t e;
    e.sel = sel;
    e.val = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel < 4) address = 32'(e.sel) << 2;
      #1;
      obs = (e.sel == EXPO) ? {31'b0, o_expired} : rd;
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input logic [31:0] data);
    we      = 1'b1;
    address = 32'(off) << 2;
    wd      = data;
    @(posedge clk);
    #1;
    we      = 1'b0;
    wd      = '0;
  endtask

  task automatic all_zero(input string tag);
    push(CTRL,  0, {tag, "_ctrl"});
    push(LOAD,  0, {tag, "_load"});
    push(COUNT, 0, {tag, "_count"});
    push(STAT,  0, {tag, "_stat"});
    push(EXPO,  0, {tag, "_oexp"});
    drain();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    we      = 1'b0;
    wd      = '0;
    address = '0;

    repeat (3) @(posedge clk);
    #1;
    all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    all_zero("rel");

    // one-shot
    wr(LOAD, 3);
    wr(CTRL, 1);
    push(COUNT, 3, "os_c3");
    push(CTRL, 1, "os_en");
    drain();
    for (int i = 2; i >= 0; i--) begin
      step();
      push(COUNT, 32'(i), "os_cnt");
      push(STAT, 0, "os_stat0");
      drain();
    end
    step();
    push(STAT, 1, "os_stat1");
    push(EXPO, 1, "os_oexp");
    push(CTRL, 0, "os_selfclr");
    push(COUNT, 0, "os_c0");
    drain();
    step();
    push(COUNT, 0, "os_hold0");
    drain();
    wr(STAT, 1);
    push(STAT, 0, "os_w1c");
    push(EXPO, 0, "os_w1c_o");
    drain();

    // auto-reload
    wr(LOAD, 2);
    wr(CTRL, 3);
    push(COUNT, 2, "ar_c2");
    push(CTRL, 3, "ar_ctrl");
    drain();
    step();
    push(COUNT, 1, "ar_c1");
    drain();
    step();
    push(COUNT, 0, "ar_c0");
    push(STAT, 0, "ar_s0");
    drain();
    step();
    push(COUNT, 2, "ar_rl");
    push(STAT, 1, "ar_s1");
    drain();
    step();
    push(COUNT, 1, "ar_c1b");
    drain();
    wr(STAT, 1);
    push(COUNT, 0, "ar_c0b");
    push(STAT, 0, "ar_w1c");
    drain();
    step();
    push(COUNT, 2, "ar_rl2");
    push(STAT, 1, "ar_s1b");
    drain();
    wr(CTRL, 0);
    push(COUNT, 2, "stop_hold");
    push(CTRL, 0, "stop_ctrl");
    drain();
    step();
    push(COUNT, 2, "stop_hold2");
    drain();
    wr(COUNT, 7);
    push(COUNT, 2, "count_ro");
    drain();
    wr(STAT, 1);

    // expiry vs W1C on the same edge
    wr(LOAD, 1);
    wr(CTRL, 1);
    step();
    push(COUNT, 0, "col_c0");
    drain();
    wr(STAT, 1);
    push(STAT, 1, "col_setwins");
    drain();
    wr(STAT, 0);
    push(STAT, 1, "col_w0");
    drain();
    wr(STAT, 1);
    push(STAT, 0, "col_w1");
    drain();
    wr(STAT, 0);
    push(STAT, 0, "col_w0b");
    drain();

    // re-enable from DONE: no reload, immediate expiry
    wr(CTRL, 1);
    push(COUNT, 0, "done_noreload");
    push(CTRL, 1, "done_run");
    push(STAT, 0, "done_s0");
    drain();
    step();
    push(STAT, 1, "done_exp");
    push(CTRL, 0, "done_clr");
    drain();
    wr(STAT, 1);

    // prescaler
    wr(LOAD, 2);
    wr(CTRL, 32'h101);
`ifdef TIMER_PRESCALER_EN
    push(CTRL, 32'h101, "ps_ctrl");
    push(COUNT, 2, "ps_c2");
    drain();
    step();
    push(COUNT, 2, "ps_n1");
    drain();
    step();
    push(COUNT, 1, "ps_n2");
    drain();
    step();
    push(COUNT, 1, "ps_n3");
    drain();
    step();
    push(COUNT, 0, "ps_n4");
    drain();
    step();
    push(STAT, 0, "ps_n5");
    drain();
    step();
    push(STAT, 1, "ps_n6");
    push(CTRL, 32'h100, "ps_ctrl_done");
    drain();
`else
    push(CTRL, 32'h1, "ps_ctrl");
    drain();
    step();
    push(COUNT, 1, "ps_n1");
    drain();
    step();
    push(COUNT, 0, "ps_n2");
    push(STAT, 0, "ps_s0");
    drain();
    step();
    push(STAT, 1, "ps_n3");
    push(CTRL, 0, "ps_ctrl_done");
    drain();
`endif
    wr(STAT, 1);
    wr(CTRL, 32'hFFFF_FE02);
`ifdef TIMER_PRESCALER_EN
    push(CTRL, 32'h0000_FE02, "ctrl_mask");
`else
    push(CTRL, 32'h0000_0002, "ctrl_mask");
`endif
    drain();
    wr(CTRL, 0);

    // mid-run reload
    wr(LOAD, 10);
    wr(CTRL, 1);
    push(COUNT, 10, "mr_c10");
    drain();
    step();
    step();
    push(COUNT, 8, "mr_c8");
    drain();
    wr(LOAD, 1);
    push(COUNT, 1, "mr_reload");
    push(LOAD, 1, "mr_load");
    drain();
    step();
    push(COUNT, 0, "mr_c0");
    push(STAT, 0, "mr_s0");
    drain();
    step();
    push(STAT, 1, "mr_exp");
    drain();

    // asynchronous reset mid-count
    wr(LOAD, 10);
    wr(CTRL, 1);
    step();
    step();
    push(COUNT, 8, "ar_pre");
    drain();
    #20;
    rst_n = 1'b0;
    #1;
    all_zero("arst");
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
